// File: rtl/multiplexer_n_to_1_reg.sv
// rtl/multiplexer_n_to_1_reg.sv - registered N-to-1 multiplexer with explicit and round-robin select
module multiplexer_n_to_1_reg #(
  parameter int N_BITS        = 32,
  parameter int N_INPUTS      = 4,
  parameter int DEFAULT_INDEX = 0,
  localparam int SEL_BITS     = (N_INPUTS > 2) ? $clog2(N_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic                         flush_i,
  input  logic                         mode_i,
  input  logic [SEL_BITS-1:0]          selector_i,
  input  logic [N_INPUTS*N_BITS-1:0]   data_i,
  input  logic [N_INPUTS-1:0]          valid_i,
  output logic [N_BITS-1:0]            mux_o,
  output logic                         valid_o,
  output logic [SEL_BITS-1:0]          sel_o,
  output logic                         sel_error_o
);

  localparam logic [SEL_BITS:0]   N_IN_W   = (SEL_BITS+1)'(N_INPUTS);
  localparam logic [SEL_BITS-1:0] DEF_SEL  = SEL_BITS'(DEFAULT_INDEX);
  localparam logic [SEL_BITS-1:0] LAST_SEL = SEL_BITS'(N_INPUTS - 1);

  logic [N_BITS-1:0]   data_arr [N_INPUTS];
  logic                in_range;
  logic [SEL_BITS-1:0] exp_sel;
  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] rr_grant;
  logic [SEL_BITS-1:0] rr_next;
  logic                rr_found;

  always_comb begin
    for (int k = 0; k < N_INPUTS; k++) begin
      data_arr[k] = data_i[k*N_BITS +: N_BITS];
    end
  end

  // With a power-of-two input count every selector value is legal.
  assign in_range = {1'b0, selector_i} < N_IN_W;
  assign exp_sel  = in_range ? selector_i : DEF_SEL;

  // Walk offsets from far to near so the nearest valid input after rr_ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_grant = '0;
    for (int off = N_INPUTS - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_INPUTS) idx = idx - N_INPUTS;
      if (valid_i[idx]) begin
        rr_found = 1'b1;
        rr_grant = SEL_BITS'(idx);
      end
    end
  end

  assign rr_next = (rr_grant == LAST_SEL) ? '0 : rr_grant + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_o       <= '0;
      valid_o     <= 1'b0;
      sel_o       <= '0;
      sel_error_o <= 1'b0;
      rr_ptr      <= '0;
    end else if (flush_i) begin
      mux_o   <= '0;
      valid_o <= 1'b0;
    end else if (enable_i) begin
      if (mode_i) begin
        if (rr_found) begin
          mux_o   <= data_arr[rr_grant];
          valid_o <= 1'b1;
          sel_o   <= rr_grant;
          rr_ptr  <= rr_next;
        end else begin
          valid_o <= 1'b0;
        end
      end else begin
        mux_o   <= data_arr[exp_sel];
        valid_o <= valid_i[exp_sel];
        sel_o   <= exp_sel;
        if (!in_range) sel_error_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiplexer_n_to_1_reg.sv
// tb/tb_multiplexer_n_to_1_reg.sv - self-checking bench for multiplexer_n_to_1_reg
module tb_multiplexer_n_to_1_reg;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i, flush_i, mode_i;
  logic [1:0]  selector_i;
  logic [23:0] data_i;
  logic [2:0]  valid_i;
  logic [7:0]  mux_o;
  logic        valid_o, sel_error_o;
  logic [1:0]  sel_o;

  logic [15:0] sw2_data, sw2_mux;
  logic [31:0] sw4_data, sw4_mux;
  logic [63:0] sw8_data;
  logic [7:0]  sw8_mux;
  logic        sw2_valid, sw4_valid, sw8_valid, sw2_err, sw4_err, sw8_err;
  logic [0:0]  sw2_sel;
  logic [1:0]  sw4_sel;
  logic [2:0]  sw8_sel;

  int total = 0;
  int bad   = 0;

  int m_mux, m_valid, m_sel, m_err, m_ptr;

  always #5 clk = ~clk;

  multiplexer_n_to_1_reg #(.N_BITS(8), .N_INPUTS(3), .DEFAULT_INDEX(0)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .flush_i(flush_i), .mode_i(mode_i),
    .selector_i(selector_i), .data_i(data_i), .valid_i(valid_i),
    .mux_o(mux_o), .valid_o(valid_o), .sel_o(sel_o), .sel_error_o(sel_error_o));

  multiplexer_n_to_1_reg #(.N_BITS(8), .N_INPUTS(2)) dut2 (
    .clk(clk), .reset(reset), .enable_i(1'b1), .flush_i(1'b0), .mode_i(1'b1),
    .selector_i(1'b0), .data_i(sw2_data), .valid_i(2'b11),
    .mux_o(sw2_mux[7:0]), .valid_o(sw2_valid), .sel_o(sw2_sel), .sel_error_o(sw2_err));

  multiplexer_n_to_1_reg #(.N_BITS(8), .N_INPUTS(4)) dut4 (
    .clk(clk), .reset(reset), .enable_i(1'b1), .flush_i(1'b0), .mode_i(1'b1),
    .selector_i(2'b00), .data_i(sw4_data), .valid_i(4'hf),
    .mux_o(sw4_mux[7:0]), .valid_o(sw4_valid), .sel_o(sw4_sel), .sel_error_o(sw4_err));

  multiplexer_n_to_1_reg #(.N_BITS(8), .N_INPUTS(8)) dut8 (
    .clk(clk), .reset(reset), .enable_i(1'b1), .flush_i(1'b0), .mode_i(1'b1),
    .selector_i(3'b000), .data_i(sw8_data), .valid_i(8'hff),
    .mux_o(sw8_mux), .valid_o(sw8_valid), .sel_o(sw8_sel), .sel_error_o(sw8_err));

  assign sw2_mux[15:8] = 8'h00;
  assign sw4_mux[31:8] = 24'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mux = 0; m_valid = 0; m_sel = 0; m_err = 0; m_ptr = 0;
  endtask

  // Reference behaviour written from the rules: priority flush > stall > update.
  task automatic model_edge();
    int s;
    bit found;
    if (flush_i) begin
      m_valid = 0;
      m_mux   = 0;
    end else if (enable_i) begin
      if (mode_i) begin
        found = 0;
        for (int off = 0; off < N; off++) begin
          s = (m_ptr + off) % N;
          if (!found && valid_i[s]) begin
            found   = 1;
            m_mux   = int'(data_i[s*8 +: 8]);
            m_valid = 1;
            m_sel   = s;
            m_ptr   = (s + 1) % N;
          end
        end
        if (!found) m_valid = 0;
      end else begin
        if (int'(selector_i) < N) s = int'(selector_i);
        else begin
          s = 0;
          m_err = 1;
        end
        m_mux   = int'(data_i[s*8 +: 8]);
        m_valid = int'(valid_i[s]);
        m_sel   = s;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mux"},   32'(mux_o),       32'(m_mux));
    chk({tag, ".valid"}, 32'(valid_o),     32'(m_valid));
    chk({tag, ".sel"},   32'(sel_o),       32'(m_sel));
    chk({tag, ".err"},   32'(sel_error_o), 32'(m_err));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mux"},   32'(mux_o),       32'd0);
    chk({tag, ".valid"}, 32'(valid_o),     32'd0);
    chk({tag, ".sel"},   32'(sel_o),       32'd0);
    chk({tag, ".err"},   32'(sel_error_o), 32'd0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable_i = 1'b0; flush_i = 1'b0; mode_i = 1'b0;
    selector_i = 2'd0; data_i = '0; valid_i = '0;
    for (int k = 0; k < 2; k++) sw2_data[k*8 +: 8] = 8'(k + 1);
    for (int k = 0; k < 4; k++) sw4_data[k*8 +: 8] = 8'(k + 1);
    for (int k = 0; k < 8; k++) sw8_data[k*8 +: 8] = 8'(k + 1);
    model_reset();
    #12;
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Explicit select
    enable_i = 1'b1;
    data_i = {8'h33, 8'h22, 8'h11};
    valid_i = 3'b010;
    selector_i = 2'd1;
    tick("exp_sel1");
    chk("exp_sel1_mux", 32'(mux_o), 32'h22);
    chk("exp_sel1_valid", 32'(valid_o), 32'd1);
    selector_i = 2'd2;
    tick("exp_sel2");
    chk("exp_sel2_mux", 32'(mux_o), 32'h33);
    chk("exp_sel2_valid", 32'(valid_o), 32'd0);
    selector_i = 2'd3;
    tick("exp_oor");
    chk("exp_oor_mux", 32'(mux_o), 32'h11);
    chk("exp_oor_err", 32'(sel_error_o), 32'd1);
    selector_i = 2'd1;
    tick("exp_sticky");
    chk("exp_sticky_err", 32'(sel_error_o), 32'd1);
    pulse_reset("err_clear");

    // Round-robin with pointer wrap
    mode_i = 1'b1;
    valid_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick("rr_all");
      chk("rr_all_sel", 32'(sel_o), 32'(i % 3));
    end
    valid_i = 3'b100;
    tick("rr_only2");
    chk("rr_only2_sel", 32'(sel_o), 32'd2);
    valid_i = 3'b000;
    tick("rr_none");
    chk("rr_none_mux", 32'(mux_o), 32'h33);

    // Stall, then flush with enable low, then resume
    valid_i = 3'b111;
    tick("rr_pre_stall");
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_i = 24'($urandom);
      valid_i = 3'($urandom);
      tick("stall");
    end
    flush_i = 1'b1;
    tick("flush");
    chk("flush_mux", 32'(mux_o), 32'd0);
    flush_i = 1'b0;
    enable_i = 1'b1;
    valid_i = 3'b111;
    tick("resume");

    // Asynchronous reset between edges
    tick("rr_before_async");
    #3;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    valid_i = 3'b110;
    tick("after_async");
    chk("after_async_sel", 32'(sel_o), 32'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      enable_i   = ($urandom % 5) != 0;
      flush_i    = ($urandom % 8) == 0;
      mode_i     = 1'($urandom);
      selector_i = 2'($urandom);
      valid_i    = 3'($urandom);
      data_i     = 24'($urandom);
      tick("random");
    end

    // Power-of-two sweep: strict rotation, never an error
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      chk("sweep2_sel", 32'(sw2_sel), 32'(c % 2));
      chk("sweep2_mux", 32'(sw2_mux), 32'(c % 2 + 1));
      chk("sweep2_err", 32'(sw2_err), 32'd0);
      chk("sweep2_valid", 32'(sw2_valid), 32'd1);
      chk("sweep4_sel", 32'(sw4_sel), 32'(c % 4));
      chk("sweep4_mux", 32'(sw4_mux), 32'(c % 4 + 1));
      chk("sweep4_err", 32'(sw4_err), 32'd0);
      chk("sweep4_valid", 32'(sw4_valid), 32'd1);
      chk("sweep8_sel", 32'(sw8_sel), 32'(c % 8));
      chk("sweep8_mux", 32'(sw8_mux), 32'(c % 8 + 1));
      chk("sweep8_err", 32'(sw8_err), 32'd0);
      chk("sweep8_valid", 32'(sw8_valid), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplexer_n_to_1_reg.md
MULTIPLEXER_N_TO_1_REG -- requirements
Module: multiplexer_n_to_1_reg

Interface
REQ-001 The block SHALL have the parameter N_BITS, default 32, giving the data width per input.
REQ-002 The block SHALL have the parameter N_INPUTS, default 4, giving the input count; legal range 2..8.
REQ-003 The block SHALL have the parameter DEFAULT_INDEX, default 0, giving the input selected on an out-of-range selector.
REQ-004 The block SHALL have the derived localparam SEL_BITS = clog2(N_INPUTS), minimum 1.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the port enable_i, input, 1 bit: 1 = advance, 0 = stall (hold all state).
REQ-008 The block SHALL have the port flush_i, input, 1 bit: invalidate the output register.
REQ-009 The block SHALL have the port mode_i, input, 1 bit: 0 = explicit select, 1 = round-robin select.
REQ-010 The block SHALL have the port selector_i, input, SEL_BITS: the explicit-mode index.
REQ-011 The block SHALL have the port data_i, input, N_INPUTS*N_BITS: packed inputs; input k occupies bits [k*N_BITS +: N_BITS].
REQ-012 The block SHALL have the port valid_i, input, N_INPUTS: per-input valid.
REQ-013 The block SHALL have the port mux_o, output, N_BITS: registered selected data.
REQ-014 The block SHALL have the port valid_o, output, 1 bit: mux_o holds a valid selection.
REQ-015 The block SHALL have the port sel_o, output, SEL_BITS: index that produced the current mux_o.
REQ-016 The block SHALL have the port sel_error_o, output, 1 bit: sticky flag for an out-of-range selector.

Function
REQ-017 All outputs SHALL be registered, with a latency of exactly 1 clk from inputs to outputs.
REQ-018 Priority per edge SHALL be reset > flush_i > enable_i = 0 (hold) > normal update.
REQ-019 Flush (flush_i = 1, regardless of enable_i) SHALL set valid_o = 0 and mux_o = 0, hold sel_o, and leave the round-robin pointer and sel_error_o unchanged.
REQ-020 Stall (enable_i = 0, flush_i = 0) SHALL hold mux_o, valid_o, sel_o, the pointer and sel_error_o.
REQ-021 In explicit mode, when selector_i < N_INPUTS: mux_o <= input[selector_i], valid_o <= valid_i[selector_i], sel_o <= selector_i.
REQ-022 In explicit mode, when selector_i >= N_INPUTS: mux_o <= input[DEFAULT_INDEX], valid_o <= valid_i[DEFAULT_INDEX], sel_o <= DEFAULT_INDEX, and sel_error_o <= 1.
REQ-023 In explicit mode the data path SHALL be transferred regardless of valid_i; valid_o only reports the corresponding valid_i bit.
REQ-024 Round-robin mode SHALL keep an internal pointer rr_ptr (SEL_BITS bits, range 0..N_INPUTS-1).
REQ-025 In round-robin mode the grant SHALL be the first index k with valid_i[k] = 1, searched rr_ptr, rr_ptr+1, ... modulo N_INPUTS.
REQ-026 On a round-robin grant: mux_o <= input[k], valid_o <= 1, sel_o <= k, and rr_ptr <= (k+1) mod N_INPUTS, wrapping from N_INPUTS-1 to 0.
REQ-027 When no valid_i bit is set in round-robin mode: valid_o <= 0, mux_o and sel_o hold, and rr_ptr holds.
REQ-028 rr_ptr SHALL change only on a round-robin grant; explicit-mode cycles, stalls and flushes SHALL leave it unchanged.
REQ-029 A change of mode_i SHALL take effect on the next enabled edge, with no idle cycle inserted.
REQ-030 sel_error_o SHALL be set only by REQ-022 and cleared only by reset; round-robin mode never sets it.
REQ-031 When N_INPUTS is a power of two, the out-of-range condition SHALL be unreachable and sel_error_o SHALL remain 0.

Reset
REQ-032 Asserting reset SHALL immediately, without waiting for clk, force mux_o = 0, valid_o = 0, sel_o = 0, sel_error_o = 0 and rr_ptr = 0.
REQ-033 Reset asserted mid-operation, including during a stall or flush, SHALL discard all state; the first enabled edge after deassertion SHALL behave as from power-up.

Verification
REQ-034 The bench SHALL use N_BITS = 8 and N_INPUTS = 3 (DEFAULT_INDEX = 0) for the scenarios below unless stated otherwise.
REQ-035 Explicit mode: inputs {0x11, 0x22, 0x33}, valid_i = 3'b010, selector_i = 1 -> next edge gives mux_o = 0x22, valid_o = 1, sel_o = 1; selector_i = 2 -> mux_o = 0x33, valid_o = 0.
REQ-036 Out of range: selector_i = 3 -> mux_o = 0x11, sel_o = 0, sel_error_o = 1; sel_error_o stays 1 through later legal selects and until reset.
REQ-037 Round-robin: valid_i = 3'b111 held for 4 enabled edges -> sel_o = 0, 1, 2, 0 (pointer wrap); then valid_i = 3'b100 -> sel_o = 2; then valid_i = 0 -> valid_o = 0 with mux_o held.
REQ-038 Stall and flush: enable_i = 0 for 3 cycles with inputs changing -> all outputs held; flush_i = 1 together with enable_i = 0 -> valid_o = 0, mux_o = 0, and round-robin then resumes from the retained rr_ptr.
REQ-039 Async reset: assert reset between clk edges during round-robin -> outputs read 0 before the next edge; after release, valid_i = 3'b110 grants index 1 first.
REQ-040 Parameter sweep: N_INPUTS = 2, 4 and 8 in round-robin with all inputs valid -> a strict 0..N-1 rotation and sel_error_o = 0 throughout.
